// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Pipeline-side bus of the load/store unit: a valid/ready request channel from
// the execute/memory stage and a single-cycle response channel for writeback.
//
// Signals
//   req_valid   pipeline presents a memory op
//   req_ready   unit can accept an op (idle)
//   req_write   1 = store, 0 = load
//   req_funct3  RV32I load/store funct3
//   req_addr    effective byte address
//   req_wdata   store data, right-justified
//   req_rd      destination register tag
//   resp_valid  one-cycle completion pulse
//   resp_rdata  extended load data (0 for stores and faults)
//   resp_rd     echoed destination register tag
//   resp_fault  op rejected without a memory access
//
// Modports: master = pipeline, slave = load/store unit.
// ----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store unit for the RV32I core. Accepts one op at a time,
// rejects illegal funct3, misaligned and out-of-range accesses, drives the
// byte-lane data BRAM (registered 1-cycle read) and returns sign/zero-extended
// load data as a registered single-cycle response.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   lsu         pipeline request/response bus (slave side)
//   mem_write   BRAM write strobe (only in the access cycle of a legal store)
//   mem_funct3  latched funct3 for the BRAM lane logic
//   mem_addr    latched byte address
//   mem_din     latched store data, unmodified
//   mem_dout    BRAM read data, lane k = byte at mem_addr + k
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_unit_if.slave      lsu,
    output logic                  mem_write,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

    state_e state_q, state_d;

    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            rd_q;
    logic [31:0]           resp_rdata_q;
    logic                  resp_fault_q;
    logic [4:0]            resp_rd_q;

    logic        transfer;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;
    logic [31:0] load_data;

    assign transfer = lsu.req_valid && (state_q == StIdle);

    // Fault evaluation on the incoming request (used only at transfer).
    always_comb begin
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = |lsu.req_addr[31:ADDR_WIDTH];
        case (lsu.req_funct3)
            3'b000:         illegal = 1'b0;
            3'b001:         misaligned = lsu.req_addr[0];
            3'b010:         misaligned = |lsu.req_addr[1:0];
            3'b100:         illegal = lsu.req_write;
            3'b101: begin
                illegal    = lsu.req_write;
                misaligned = lsu.req_addr[0];
            end
            default:        illegal = 1'b1;
        endcase
        req_fault = illegal || misaligned || out_of_range;
    end

    // Load formatting of the BRAM word, indexed by the latched funct3.
    always_comb begin
        load_data = mem_dout;
        case (funct3_q)
            3'b000:  load_data = {{24{mem_dout[7]}}, mem_dout[7:0]};
            3'b100:  load_data = {24'h0, mem_dout[7:0]};
            3'b001:  load_data = {{16{mem_dout[15]}}, mem_dout[15:0]};
            3'b101:  load_data = {16'h0, mem_dout[15:0]};
            default: load_data = mem_dout;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (transfer) begin
                    state_d = req_fault ? StResp : StAccess;
                end
            end
            StAccess:  state_d = write_q ? StResp : StCapture;
            StCapture: state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs. The reset gate on mem_write kills a store aborted mid-access.
    always_comb begin
        lsu.req_ready  = (state_q == StIdle);
        lsu.resp_valid = (state_q == StResp);
        mem_write      = (state_q == StAccess) && write_q && !reset;
    end

    // Request latches and response registers. Response registers are only
    // written on the edge that enters StResp, so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            rd_q         <= 5'd0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= 5'd0;
        end else begin
            if (transfer) begin
                write_q  <= lsu.req_write;
                funct3_q <= lsu.req_funct3;
                addr_q   <= lsu.req_addr[ADDR_WIDTH-1:0];
                wdata_q  <= lsu.req_wdata;
                rd_q     <= lsu.req_rd;
                if (req_fault) begin
                    resp_rdata_q <= 32'h0;
                    resp_fault_q <= 1'b1;
                    resp_rd_q    <= lsu.req_rd;
                end
            end
            if (state_q == StAccess && write_q) begin
                resp_rdata_q <= 32'h0;
                resp_fault_q <= 1'b0;
                resp_rd_q    <= rd_q;
            end
            if (state_q == StCapture) begin
                resp_rdata_q <= load_data;
                resp_fault_q <= 1'b0;
                resp_rd_q    <= rd_q;
            end
        end
    end

    assign mem_funct3     = funct3_q;
    assign mem_addr       = addr_q;
    assign mem_din        = wdata_q;
    assign lsu.resp_rdata = resp_rdata_q;
    assign lsu.resp_fault = resp_fault_q;
    assign lsu.resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Bench for load_store_unit: a behavioural byte-lane BRAM, a directed vector
// table, hand-written back-to-back and reset-abort sequences, and random ops
// checked against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [10:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        bram_clear;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.ADDR_WIDTH(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu        (bus.slave),
        .mem_write  (mem_write),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Byte-lane BRAM with registered read.
    logic [7:0] bram [2048];
    always @(posedge clk) begin
        if (bram_clear) begin
            for (int i = 0; i < 2048; i++) bram[i] <= 8'h00;
        end else if (mem_write) begin
            bram[mem_addr] <= mem_din[7:0];
            if (mem_funct3[1:0] != 2'b00) bram[mem_addr + 11'd1] <= mem_din[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                bram[mem_addr + 11'd2] <= mem_din[23:16];
                bram[mem_addr + 11'd3] <= mem_din[31:24];
            end
        end
        mem_dout <= {bram[mem_addr + 11'd3], bram[mem_addr + 11'd2],
                     bram[mem_addr + 11'd1], bram[mem_addr]};
    end

    int wr_pulses = 0;
    always @(posedge clk) if (mem_write === 1'b1) wr_pulses++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory and model: size/legality/alignment from the ISA rules.
    logic [7:0] ref_mem [2048];

    task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic fault);
        int     size;
        bit     legal;
        longint v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        legal = (f3 <= 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
        fault = !legal || (int'(addr % 32'(size)) != 0) || (addr >= 32'd2048);
        rdata = 32'h0;
        if (!fault) begin
            if (wr) begin
                for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
                if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v -= longint'(1) << (8 * size);
                rdata = v[31:0];
            end
        end
    endtask

    // Issue one op from an idle cycle (#1 after an edge); returns response,
    // latency in cycles after transfer (-1 on timeout) and write-strobe count.
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          output logic [31:0] rdata, output logic fault,
                          output logic [4:0] rd_o, output int lat, output int pulses);
        int p0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        check("req_ready_before_op", 32'(bus.req_ready), 32'd1);
        p0 = wr_pulses;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 6; n++) begin
            if (bus.resp_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        rdata = bus.resp_rdata;
        fault = bus.resp_fault;
        rd_o  = bus.resp_rd;
        @(posedge clk); #1;
        pulses = wr_pulses - p0;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [18];

    logic [31:0] rdata, exp_rdata;
    logic        fault, exp_fault;
    logic [4:0]  rd_o;
    int          lat, pulses, exp_lat, seen, p_before;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 5'd1,  32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h010, 32'h0,        5'd2,  32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h013, 32'h000000F0, 5'd3,  32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h013, 32'h0,        5'd4,  32'hFFFFFFF0, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h013, 32'h0,        5'd5,  32'h000000F0, 1'b0};
        vecs[5]  = '{1'b1, 3'b001, 32'h022, 32'h00008001, 5'd6,  32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 32'h022, 32'h0,        5'd7,  32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h022, 32'h0,        5'd8,  32'h00008001, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 32'h020, 32'h0,        5'd9,  32'h80010000, 1'b0};
        vecs[9]  = '{1'b0, 3'b010, 32'h012, 32'h0,        5'd10, 32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 3'b001, 32'h021, 32'h0000FFFF, 5'd11, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 3'b010, 32'h800, 32'h11111111, 5'd12, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 3'b011, 32'h010, 32'h0,        5'd13, 32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 3'b100, 32'h040, 32'h000000AA, 5'd14, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 3'b101, 32'h023, 32'h0,        5'd15, 32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 3'b000, 32'h80000010, 32'h0,   5'd16, 32'h00000000, 1'b1};
        vecs[16] = '{1'b0, 3'b010, 32'h010, 32'h0,        5'd17, 32'hF0ADBEEF, 1'b0};
        vecs[17] = '{1'b0, 3'b000, 32'h012, 32'h0,        5'd18, 32'hFFFFFFAD, 1'b0};

        reset = 1'b1;
        bram_clear = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_rd = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bram_clear = 1'b0;

        // Reset state.
        check("rst_req_ready",  32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_rd",    32'(bus.resp_rd), 32'd0);
        check("rst_mem_write",  32'(mem_write), 32'd0);
        check("rst_mem_addr",   32'(mem_addr), 32'd0);
        check("rst_mem_funct3", 32'(mem_funct3), 32'd0);
        check("rst_mem_din",    mem_din, 32'h0);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                   rdata, fault, rd_o, lat, pulses);
            exp_lat = vecs[i].exp_fault ? 1 : (vecs[i].wr ? 2 : 3);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
            check($sformatf("vec%0d_rd", i), 32'(rd_o), 32'(vecs[i].rd));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("vec%0d_mem_write_pulses", i), 32'(pulses),
                  32'((vecs[i].wr && !vecs[i].exp_fault) ? 1 : 0));
        end

        // Back-to-back loads with req_valid held high.
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) begin
                bus.req_valid  = 1'b1;
                bus.req_write  = 1'b0;
                bus.req_funct3 = 3'b010;
                bus.req_addr   = 32'h010;
                bus.req_rd     = 5'd20;
            end
            if (k == 8) bus.req_valid = 1'b0;
            check($sformatf("b2b_ready_c%0d", k), 32'(bus.req_ready),
                  32'((k == 0 || k == 4 || k == 8) ? 1 : 0));
            check($sformatf("b2b_resp_valid_c%0d", k), 32'(bus.resp_valid),
                  32'((k == 3 || k == 7) ? 1 : 0));
            if (k == 3 || k == 7) begin
                check($sformatf("b2b_rdata_c%0d", k), bus.resp_rdata, 32'hF0ADBEEF);
                check($sformatf("b2b_rd_c%0d", k), 32'(bus.resp_rd), 32'd20);
            end
            @(posedge clk); #1;
        end

        // Reset during the access cycle of a store.
        run_op(1'b1, 3'b010, 32'h030, 32'hCAFEF00D, 5'd21, rdata, fault, rd_o, lat, pulses);
        check("pre_reset_store_latency", 32'(lat), 32'd2);
        p_before = wr_pulses;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h030;
        bus.req_wdata  = 32'h12345678;
        bus.req_rd     = 5'd22;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_access_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_idle_ready", 32'(bus.req_ready), 32'd1);
        check("abort_resp_rdata", bus.resp_rdata, 32'h0);
        check("abort_resp_rd", 32'(bus.resp_rd), 32'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.resp_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_resp_valid", 32'(seen), 32'd0);
        check("abort_no_mem_write", 32'(wr_pulses - p_before), 32'd0);
        run_op(1'b0, 3'b010, 32'h030, 32'h0, 5'd23, rdata, fault, rd_o, lat, pulses);
        check("abort_reload_rdata", rdata, 32'hCAFEF00D);
        check("abort_reload_latency", 32'(lat), 32'd3);

        // Random ops against the reference model, from a cleared memory.
        bram_clear = 1'b1;
        @(posedge clk); #1;
        bram_clear = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 200; i++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] addr, wdata;
            logic [4:0]  rd;
            wr    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            rd    = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'($urandom_range(0, 2047));
                2, 3:    addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
                default: addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 1)) * 2;
            endcase
            model_op(wr, f3, addr, wdata, exp_rdata, exp_fault);
            exp_lat = exp_fault ? 1 : (wr ? 2 : 3);
            run_op(wr, f3, addr, wdata, rd, rdata, fault, rd_o, lat, pulses);
            check($sformatf("rnd%0d_rdata", i), rdata, exp_rdata);
            check($sformatf("rnd%0d_fault", i), 32'(fault), 32'(exp_fault));
            check($sformatf("rnd%0d_rd", i), 32'(rd_o), 32'(rd));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_mem_write_pulses", i), 32'(pulses),
                  32'((wr && !exp_fault) ? 1 : 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I core. It accepts one memory operation at a time from the execute/memory pipeline over a valid/ready handshake and checks alignment, range and funct3 legality. It drives the byte-lane data BRAM (11-bit byte address, 1-cycle registered read) and returns load data, sign- or zero-extended, as a registered single-cycle response for writeback.

## Interface
- ADDR_WIDTH, 11, byte-address width of the data BRAM; higher address bits must be zero
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns the FSM to IDLE and clears outputs
- req_valid  in  1  pipeline presents a memory op
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2), right-justified
- req_rd  in  5  destination register, passed through to resp_rd
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_rd  out  5  latched req_rd
- resp_fault  out  1  op rejected; no memory access performed
- mem_write  out  1  BRAM write strobe
- mem_funct3  out  3  latched funct3 to BRAM lane logic
- mem_addr  out  ADDR_WIDTH  latched req_addr[ADDR_WIDTH-1:0]
- mem_din  out  32  latched req_wdata, unmodified
- mem_dout  in  32  BRAM read data; lane k = byte at mem_addr+k, valid the cycle after the address is presented

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On transfer, latch write, funct3, addr, wdata and rd, then evaluate the fault:
  - Illegal funct3: 011, 110, 111; also 100 or 101 with write=1.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Out of range: addr[31:ADDR_WIDTH]≠0.
  - Fault → RESP with fault flag set. Otherwise → ACCESS.
- ACCESS: mem_addr, mem_funct3 and mem_din come from the latches; mem_write = latched write && !reset. Store → RESP; load → CAPTURE.
- CAPTURE: sample mem_dout and format it:
  - B: sign-extend [7:0]. BU: zero-extend [7:0].
  - H: sign-extend [15:0]. HU: zero-extend [15:0].
  - W: [31:0].
  - Register the result into resp_rdata, then → RESP.
- RESP: resp_valid=1 with resp_rd, resp_fault and resp_rdata stable for this cycle; → IDLE.
- mem_write=0 in every state except ACCESS. Other mem_* outputs hold the latched values in every state.
- resp_rdata, resp_fault and resp_rd hold their values after RESP until the next response overwrites them.
- Faulted ops never reach ACCESS, so a faulted store never asserts mem_write.

## Timing
- Transfer in cycle 0:
  - Load: ACCESS in cycle 1, CAPTURE in cycle 2, resp_valid in cycle 3.
  - Store: mem_write in cycle 1, resp_valid in cycle 2.
  - Fault: resp_valid in cycle 1.
- Throughput: one op per 4, 3 or 2 cycles respectively. req_ready=0 from cycle 1 until the return to IDLE. No request queuing; the pipeline holds req_* stable while stalled.
- Reset values: state IDLE, req_ready=1 in the first cycle after reset, resp_valid=0, resp_fault=0, resp_rdata=0, resp_rd=0, mem_write=0, mem_addr=0, mem_funct3=0, mem_din=0.
- Reset mid-operation: a sync reset during any state aborts the op and no resp_valid is issued. During ACCESS, mem_write is forced to 0 in that same cycle.
- A req_valid arriving while busy is ignored. A request presented in the RESP cycle is not accepted until the following IDLE cycle.

## Test plan
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 → store resp in cycle 2 with fault=0; load resp_rdata=0xDEADBEEF in cycle 3, resp_rd echoed.
- SB 0x013 data 0x000000F0, then LB 0x013 → 0xFFFFFFF0; LBU 0x013 → 0x000000F0.
- SH 0x022 data 0x00008001, then LH 0x022 → 0xFFFF8001; LHU 0x022 → 0x00008001; LW 0x020 → upper half reads 0x8001.
- LW 0x012, SH 0x021, SW 0x800, funct3=011 → each gives resp_fault=1 in cycle 1, resp_rdata=0, mem_write never asserted; a following LW 0x010 is unchanged.
- req_valid held high with two loads back-to-back → req_ready low in cycles 1–3; second transfer in cycle 4; its resp_valid in cycle 7.
- Reset asserted in the ACCESS cycle of SW 0x030 data 0x12345678 → mem_write=0 that cycle, no resp_valid, IDLE next cycle; LW 0x030 returns the prior contents.
